// File: rtl/uart_boot_pkg.sv
// Shared constants, state encoding and strobe helper for the UART boot loader.
package uart_boot_pkg;

    localparam logic [7:0] CMD_STORE = 8'h53;
    localparam logic [7:0] CMD_GO    = 8'h47;
    localparam logic [7:0] RSP_ACK   = 8'h06;
    localparam logic [7:0] RSP_NAK   = 8'h15;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ST_ADDR,
        S_ST_LEN,
        S_DATA,
        S_DRAIN,
        S_GO_ADDR,
        S_RESP
    } state_t;

    // Byte enables for a word whose highest filled lane is 'lane'.
    function automatic logic [3:0] lane_strb(input logic [1:0] lane);
        case (lane)
            2'd0:    lane_strb = 4'b0001;
            2'd1:    lane_strb = 4'b0011;
            2'd2:    lane_strb = 4'b0111;
            default: lane_strb = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/uart_boot_loader_ctrl_if.sv
// UART byte streams and memory write port of the boot loader, as one bundle.
interface uart_boot_loader_ctrl_if;

    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  tx_data;
    logic        mem_req;
    logic        mem_gnt;
    logic        mem_error;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_strb;

    modport master (
        input  rx_valid, rx_data, tx_ready, mem_gnt, mem_error,
        output tx_valid, tx_data, mem_req, mem_addr, mem_wdata, mem_strb
    );

    modport slave (
        output rx_valid, rx_data, tx_ready, mem_gnt, mem_error,
        input  tx_valid, tx_data, mem_req, mem_addr, mem_wdata, mem_strb
    );

endinterface

// File: rtl/uart_boot_word_pack.sv
// Packs payload bytes into words and holds one write on the req/gnt bus.
module uart_boot_word_pack
    import uart_boot_pkg::*;
(
    input  logic        g_clk,
    input  logic        g_reset,
    input  logic        i_base_load,
    input  logic [31:0] i_base_addr,
    input  logic        i_byte_valid,
    input  logic [7:0]  i_byte,
    input  logic [1:0]  i_lane,
    input  logic        i_last,
    input  logic        i_mem_gnt,
    output logic        o_mem_req,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_strb,
    output logic        o_overrun,
    output logic        o_busy
);

    logic [31:0] r_assy;
    logic [31:0] r_next_addr;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_strb;
    logic        r_req;

    logic [31:0] w_word;
    logic        w_complete;
    logic        w_accept;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_word = (i_lane == 2'd0) ? 32'd0 : r_assy;
        case (i_lane)
            2'd0:    w_word[7:0]   = i_byte;
            2'd1:    w_word[15:8]  = i_byte;
            2'd2:    w_word[23:16] = i_byte;
            default: w_word[31:24] = i_byte;
        endcase
    end

    assign w_complete = i_byte_valid && ((i_lane == 2'd3) || i_last);
    // A grant in the same cycle frees the write register for the new word.
    assign w_accept   = w_complete && (!r_req || i_mem_gnt);
    assign o_overrun  = w_complete && !w_accept;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            r_assy      <= '0;
            r_next_addr <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_strb      <= '0;
            r_req       <= 1'b0;
        end else begin
            if (i_byte_valid)
                r_assy <= w_word;
            if (i_base_load)
                r_next_addr <= i_base_addr;
            else if (w_complete)
                r_next_addr <= r_next_addr + 32'd4;
            if (w_accept) begin
                r_req   <= 1'b1;
                r_addr  <= r_next_addr;
                r_wdata <= w_word;
                r_strb  <= lane_strb(i_lane);
            end else if (r_req && i_mem_gnt) begin
                r_req <= 1'b0;
            end
        end
    end

    assign o_mem_req   = r_req;
    assign o_mem_addr  = r_addr;
    assign o_mem_wdata = r_wdata;
    assign o_mem_strb  = r_strb;
    assign o_busy      = r_req;

endmodule

// File: rtl/uart_boot_loader_ctrl.sv
// Host command frame sequencer: STORE writes memory, GO releases the CPU; each frame gets ACK/NAK.
module uart_boot_loader_ctrl
    import uart_boot_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES  = 2_000_000,
    parameter logic [31:0] RESET_BOOT_ADDR = 32'h0000_0000
)(
    input  logic                    g_clk,
    input  logic                    g_reset,
    uart_boot_loader_ctrl_if.master bus,
    output logic                    cpu_hold,
    output logic [31:0]             boot_addr
);

    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_cnt;
    logic [31:0] r_shift;
    logic [31:0] r_len;
    logic [31:0] r_idle_cnt;
    logic [31:0] r_boot_addr;
    logic        r_cpu_hold;
    logic        r_err;
    logic [7:0]  r_tx_data;

    logic [31:0] w_field;
    logic        w_field_done;
    logic        w_counting;
    logic        w_timeout;
    logic        w_last;
    logic        w_err_set;
    logic        w_overrun;
    logic        w_busy;

    // Multi-byte fields arrive little-endian, so each byte enters at the top.
    assign w_field      = {bus.rx_data, r_shift[31:8]};
    assign w_field_done = bus.rx_valid && (r_cnt[1:0] == 2'd3);
    assign w_counting   = r_state inside {S_ST_ADDR, S_ST_LEN, S_DATA, S_GO_ADDR};
    assign w_timeout    = w_counting && !bus.rx_valid && (r_idle_cnt == TIMEOUT_LAST);
    assign w_last       = (r_cnt == r_len - 32'd1);

    always_comb begin
        w_next    = r_state;
        w_err_set = 1'b0;
        case (r_state)
            S_IDLE: if (bus.rx_valid) begin
                if (bus.rx_data == CMD_STORE)   w_next = S_ST_ADDR;
                else if (bus.rx_data == CMD_GO) w_next = S_GO_ADDR;
                else begin
                    w_err_set = 1'b1;
                    w_next    = S_RESP;
                end
            end
            S_ST_ADDR: if (w_field_done) begin
                if (w_field[1:0] != 2'b00) begin
                    w_err_set = 1'b1;
                    w_next    = S_RESP;
                end else begin
                    w_next = S_ST_LEN;
                end
            end
            S_ST_LEN:  if (w_field_done) w_next = (w_field == 32'd0) ? S_RESP : S_DATA;
            S_DATA:    if (bus.rx_valid && w_last) w_next = S_DRAIN;
            S_DRAIN:   if (!w_busy || bus.mem_gnt) w_next = S_RESP;
            S_GO_ADDR: if (w_field_done) w_next = S_RESP;
            S_RESP:    if (bus.tx_ready) w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
        if (w_timeout) begin
            w_err_set = 1'b1;
            w_next    = S_RESP;
        end
        if (w_overrun || (bus.mem_req && bus.mem_gnt && bus.mem_error))
            w_err_set = 1'b1;
    end

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_shift     <= '0;
            r_len       <= '0;
            r_idle_cnt  <= '0;
            r_boot_addr <= RESET_BOOT_ADDR;
            r_cpu_hold  <= 1'b1;
            r_err       <= 1'b0;
            r_tx_data   <= '0;
        end else begin
            r_state    <= w_next;
            r_idle_cnt <= (w_counting && !bus.rx_valid) ? r_idle_cnt + 32'd1 : 32'd0;
            if (r_state != w_next)
                r_cnt <= '0;
            else if (bus.rx_valid && w_counting)
                r_cnt <= r_cnt + 32'd1;
            if (bus.rx_valid)
                r_shift <= w_field;
            if (r_state == S_ST_LEN && w_field_done)
                r_len <= w_field;
            if (r_state == S_GO_ADDR && w_field_done) begin
                r_boot_addr <= w_field;
                r_cpu_hold  <= 1'b0;
            end
            if (r_state == S_RESP && bus.tx_ready)
                r_err <= 1'b0;
            if (w_err_set)
                r_err <= 1'b1;
            // Response byte is frozen on entry so a late write error cannot alter it mid-handshake.
            if (w_next == S_RESP && r_state != S_RESP)
                r_tx_data <= (r_err || w_err_set) ? RSP_NAK : RSP_ACK;
        end
    end

    uart_boot_word_pack u_pack (
        .g_clk        (g_clk),
        .g_reset      (g_reset),
        .i_base_load  (r_state == S_ST_ADDR && w_field_done),
        .i_base_addr  (w_field),
        .i_byte_valid (bus.rx_valid && r_state == S_DATA),
        .i_byte       (bus.rx_data),
        .i_lane       (r_cnt[1:0]),
        .i_last       (w_last),
        .i_mem_gnt    (bus.mem_gnt),
        .o_mem_req    (bus.mem_req),
        .o_mem_addr   (bus.mem_addr),
        .o_mem_wdata  (bus.mem_wdata),
        .o_mem_strb   (bus.mem_strb),
        .o_overrun    (w_overrun),
        .o_busy       (w_busy)
    );

    assign bus.tx_valid = (r_state == S_RESP);
    assign bus.tx_data  = r_tx_data;
    assign cpu_hold     = r_cpu_hold;
    assign boot_addr    = r_boot_addr;

endmodule

// File: tb/tb_uart_boot_loader_ctrl.sv
// Self-checking bench: directed frames plus random STOREs against a frame-level write model.
module tb_uart_boot_loader_ctrl;
    import uart_boot_pkg::*;

    localparam int TO = 300;

    logic        g_clk = 1'b0;
    logic        g_reset = 1'b1;
    logic        cpu_hold;
    logic [31:0] boot_addr;

    uart_boot_loader_ctrl_if bus();

    uart_boot_loader_ctrl #(
        .TIMEOUT_CYCLES  (TO),
        .RESET_BOOT_ADDR (32'h0000_0000)
    ) dut (
        .g_clk     (g_clk),
        .g_reset   (g_reset),
        .bus       (bus),
        .cpu_hold  (cpu_hold),
        .boot_addr (boot_addr)
    );

    always #5 g_clk = ~g_clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } wr_t;

    wr_t        exp_q[$];
    wr_t        act_q[$];
    logic [7:0] pay[$];
    int n_cmp = 0;
    int n_bad = 0;
    int gnt_delay = 0;
    int req_age = 0;
    int grant_cnt = 0;
    int err_grant = 0;
    int req_cycles = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Memory responder: grants after gnt_delay cycles of request, logs each accepted write.
    always @(negedge g_clk) begin
        if (bus.mem_gnt) req_age = 0;
        if (bus.mem_req) req_cycles++;
        if (!g_reset && bus.mem_req && req_age >= gnt_delay) begin
            grant_cnt++;
            bus.mem_gnt   = 1'b1;
            bus.mem_error = (grant_cnt == err_grant);
            act_q.push_back('{addr: bus.mem_addr, data: bus.mem_wdata, strb: bus.mem_strb});
        end else begin
            bus.mem_gnt   = 1'b0;
            bus.mem_error = 1'b0;
        end
        if (bus.mem_req) req_age++;
        else             req_age = 0;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge g_clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        @(negedge g_clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    // Expected writes: consecutive words from addr, bytes little-endian, enables for present bytes.
    task automatic model_store(input logic [31:0] addr);
        wr_t w;
        for (int i = 0; i < pay.size(); i += 4) begin
            w.addr = addr + 32'(i);
            w.data = '0;
            w.strb = '0;
            for (int j = 0; j < 4; j++) begin
                if (i + j < pay.size()) begin
                    w.data[8*j +: 8] = pay[i+j];
                    w.strb[j]        = 1'b1;
                end
            end
            exp_q.push_back(w);
        end
    endtask

    task automatic wait_resp(input string tag, input logic [7:0] exp, output int lat);
        lat = 0;
        while (!bus.tx_valid && lat < TO + 200) begin
            @(negedge g_clk);
            lat++;
        end
        if (!bus.tx_valid) begin
            check({tag, " tx_valid within budget"}, 32'd0, 32'd1);
            return;
        end
        check({tag, " tx_data"}, bus.tx_data, exp);
        bus.tx_ready = 1'b1;
        @(negedge g_clk);
        bus.tx_ready = 1'b0;
        check({tag, " tx_valid after handshake"}, bus.tx_valid, 32'd0);
    endtask

    task automatic check_writes(input string tag);
        check({tag, " write count"}, act_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
            check($sformatf("%s w%0d addr", tag, i), act_q[i].addr, exp_q[i].addr);
            check($sformatf("%s w%0d data", tag, i), act_q[i].data, exp_q[i].data);
            check($sformatf("%s w%0d strb", tag, i), act_q[i].strb, exp_q[i].strb);
        end
        act_q.delete();
        exp_q.delete();
    endtask

    task automatic do_store(input string tag, input logic [31:0] addr, input int max_gap,
                            input logic [7:0] exp_rsp);
        int lat;
        send_byte(CMD_STORE);
        send_word(addr);
        send_word(32'(pay.size()));
        foreach (pay[i]) begin
            send_byte(pay[i]);
            if (max_gap > 0) idle($urandom_range(0, max_gap));
        end
        wait_resp(tag, exp_rsp, lat);
        check_writes(tag);
    endtask

    task automatic check_reset(input string tag);
        check({tag, " tx_valid"},  bus.tx_valid,  32'd0);
        check({tag, " tx_data"},   bus.tx_data,   32'd0);
        check({tag, " mem_req"},   bus.mem_req,   32'd0);
        check({tag, " mem_addr"},  bus.mem_addr,  32'd0);
        check({tag, " mem_wdata"}, bus.mem_wdata, 32'd0);
        check({tag, " mem_strb"},  bus.mem_strb,  32'd0);
        check({tag, " cpu_hold"},  cpu_hold,      32'd1);
        check({tag, " boot_addr"}, boot_addr,     32'h0000_0000);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int lat;
        int req_before;
        logic [31:0] a;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        bus.tx_ready = 1'b0;
        g_reset = 1'b1;
        repeat (3) @(negedge g_clk);
        check_reset("reset");
        g_reset = 1'b0;
        @(negedge g_clk);

        pay.delete();
        for (int i = 0; i < 8; i++) pay.push_back(8'(i));
        model_store(32'h0000_1000);
        do_store("store8", 32'h0000_1000, 0, RSP_ACK);

        pay = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
        model_store(32'h0000_2000);
        do_store("store5", 32'h0000_2000, 0, RSP_ACK);

        req_before = req_cycles;
        send_byte(CMD_STORE);
        send_word(32'h0000_1002);
        wait_resp("misaligned", RSP_NAK, lat);
        check("misaligned no mem_req", 32'(req_cycles - req_before), 32'd0);
        check_writes("misaligned");

        send_byte(8'h7F);
        wait_resp("unknown cmd", RSP_NAK, lat);

        send_byte(CMD_STORE);
        send_byte(8'h00);
        send_byte(8'h10);
        wait_resp("timeout", RSP_NAK, lat);
        check("timeout latency", 32'(lat), 32'(TO));

        gnt_delay = 100;
        pay.delete();
        for (int i = 0; i < 8; i++) pay.push_back(8'($urandom));
        model_store(32'h0000_5000);
        void'(exp_q.pop_back());
        do_store("overrun", 32'h0000_5000, 0, RSP_NAK);
        gnt_delay = 0;

        err_grant = grant_cnt + 2;
        model_store(32'h0000_6000);
        do_store("mem_error", 32'h0000_6000, 0, RSP_NAK);
        err_grant = 0;

        check("cpu_hold before GO", cpu_hold, 32'd1);
        send_byte(CMD_GO);
        send_word(32'h8000_0000);
        check("go cpu_hold", cpu_hold, 32'd0);
        check("go boot_addr", boot_addr, 32'h8000_0000);
        check("go tx_valid", bus.tx_valid, 32'd1);
        for (int i = 0; i < 50; i++) begin
            check($sformatf("go hold c%0d tx_valid", i), bus.tx_valid, 32'd1);
            check($sformatf("go hold c%0d tx_data", i), bus.tx_data, RSP_ACK);
            @(negedge g_clk);
        end
        wait_resp("go", RSP_ACK, lat);

        send_byte(CMD_GO);
        send_word(32'h1234_5678);
        wait_resp("go2", RSP_ACK, lat);
        check("go2 boot_addr", boot_addr, 32'h1234_5678);
        check("go2 cpu_hold", cpu_hold, 32'd0);

        for (int k = 0; k < 8; k++) begin
            a = (k == 3) ? 32'hFFFF_FFF8 : {$urandom(), 2'b00} & 32'hFFFF_FFFC;
            pay.delete();
            for (int i = 0; i < $urandom_range(1, 12); i++) pay.push_back(8'($urandom));
            model_store(a);
            do_store($sformatf("rand%0d", k), a, 2, RSP_ACK);
        end

        gnt_delay = 100;
        send_byte(CMD_STORE);
        send_word(32'h0000_3000);
        send_word(32'd8);
        for (int i = 0; i < 4; i++) send_byte(8'(8'h30 + i));
        check("store mem_req latency", bus.mem_req, 32'd1);
        send_byte(8'h34);
        g_reset = 1'b1;
        @(negedge g_clk);
        check_reset("mid-data reset");
        g_reset = 1'b0;
        gnt_delay = 0;
        act_q.delete();
        exp_q.delete();
        @(negedge g_clk);
        pay.delete();
        for (int i = 0; i < 6; i++) pay.push_back(8'($urandom));
        model_store(32'h0000_4000);
        do_store("after reset", 32'h0000_4000, 1, RSP_ACK);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
